// File: rtl/hub75_frame_scanner.sv
`default_nettype none
// ============================================================================
// hub75_frame_scanner : double-buffered 32x32x3 frame store with HUB75 1:16 scan
// Revision 1.0 - initial release
// ============================================================================
module hub75_frame_scanner #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned DISPLAY_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [2:0] wr_rgb,
  input  logic       swap_req,
  output logic       swap_pending,
  output logic       frame_start,
  output logic       r1,
  output logic       g1,
  output logic       b1,
  output logic       r2,
  output logic       g2,
  output logic       b2,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       lat,
  output logic       oe,
  output logic       led_clk
);

  localparam int unsigned CMAX = (DISPLAY_CYCLES > CLK_DIV) ? DISPLAY_CYCLES : CLK_DIV;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DISP_LAST = CW'(DISPLAY_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SHIFT   = 2'd0,
    ST_BLANK   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_DISPLAY = 2'd3
  } state_e;

  state_e          state_q;
  logic [4:0]      col_q;
  logic [3:0]      row_q;
  logic [CW-1:0]   cnt_q;
  logic            disp_bank_q;
  logic            swap_pending_q;
  logic            frame_start_q;
  logic            oe_q;
  logic            lat_q;
  logic            led_clk_q;
  logic [2:0]      rgb1_q;
  logic [2:0]      rgb2_q;
  logic [3:0]      addr_q;
  logic            init_q;

  // Address layout {bank, y[4:0], x[4:0]}
  logic [2:0]      mem_q [0:2047];

  logic            exit_row_d;
  logic            take_swap_d;
  logic            fetch_bank_d;
  logic [4:0]      fetch_col_d;
  logic [3:0]      fetch_row_d;
  logic [10:0]     wr_addr_d;
  logic [10:0]     top_addr_d;
  logic [10:0]     bot_addr_d;
  logic [2:0]      pix_top_d;
  logic [2:0]      pix_bot_d;

  // Fetch the pixel pair for the column that becomes current at the next edge;
  // the bypass lets a same-cycle write (e.g. in the swap cycle) be shown at once.
  always_comb begin
    exit_row_d   = (state_q == ST_DISPLAY) && (cnt_q == DISP_LAST);
    take_swap_d  = exit_row_d && (row_q == 4'd15) && (swap_pending_q || swap_req);
    wr_addr_d    = {~disp_bank_q, wr_y, wr_x};
    fetch_bank_d = disp_bank_q;
    fetch_col_d  = col_q + 5'd1;
    fetch_row_d  = row_q;
    if (init_q) begin
      fetch_col_d = 5'd0;
    end else if (exit_row_d) begin
      fetch_bank_d = disp_bank_q ^ take_swap_d;
      fetch_col_d  = 5'd0;
      fetch_row_d  = row_q + 4'd1;
    end
    top_addr_d = {fetch_bank_d, 1'b0, fetch_row_d, fetch_col_d};
    bot_addr_d = {fetch_bank_d, 1'b1, fetch_row_d, fetch_col_d};
    pix_top_d  = mem_q[top_addr_d];
    pix_bot_d  = mem_q[bot_addr_d];
    if (wr_en && (wr_addr_d == top_addr_d)) pix_top_d = wr_rgb;
    if (wr_en && (wr_addr_d == bot_addr_d)) pix_bot_d = wr_rgb;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr_d] <= wr_rgb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_SHIFT;
      col_q          <= 5'd0;
      row_q          <= 4'd0;
      cnt_q          <= '0;
      disp_bank_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_start_q  <= 1'b0;
      oe_q           <= 1'b1;
      lat_q          <= 1'b0;
      led_clk_q      <= 1'b0;
      rgb1_q         <= 3'd0;
      rgb2_q         <= 3'd0;
      addr_q         <= 4'd0;
      init_q         <= 1'b1;
    end else begin
      frame_start_q <= 1'b0;
      if (take_swap_d) begin
        swap_pending_q <= 1'b0;
      end else if (swap_req) begin
        swap_pending_q <= 1'b1;
      end

      // First cycle out of reset only loads column 0 data and flags the frame.
      if (init_q) begin
        init_q        <= 1'b0;
        frame_start_q <= 1'b1;
        rgb1_q        <= pix_top_d;
        rgb2_q        <= pix_bot_d;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (cnt_q == DIV_LAST) begin
              cnt_q <= '0;
              if (!led_clk_q) begin
                led_clk_q <= 1'b1;
              end else begin
                led_clk_q <= 1'b0;
                if (col_q == 5'd31) begin
                  state_q <= ST_BLANK;
                  addr_q  <= row_q;
                end else begin
                  col_q  <= col_q + 5'd1;
                  rgb1_q <= pix_top_d;
                  rgb2_q <= pix_bot_d;
                end
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_BLANK: begin
            if (cnt_q == DIV_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_LATCH;
              lat_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_LATCH: begin
            if (cnt_q == DIV_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_DISPLAY;
              lat_q   <= 1'b0;
              oe_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_DISPLAY: begin
            if (exit_row_d) begin
              cnt_q         <= '0;
              state_q       <= ST_SHIFT;
              oe_q          <= 1'b1;
              col_q         <= 5'd0;
              row_q         <= row_q + 4'd1;
              disp_bank_q   <= fetch_bank_d;
              rgb1_q        <= pix_top_d;
              rgb2_q        <= pix_bot_d;
              frame_start_q <= (row_q == 4'd15);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_SHIFT;
        endcase
      end
    end
  end

  assign swap_pending = swap_pending_q;
  assign frame_start  = frame_start_q;
  assign {r1, g1, b1} = rgb1_q;
  assign {r2, g2, b2} = rgb2_q;
  assign {d, c, b, a} = addr_q;
  assign lat          = lat_q;
  assign oe           = oe_q;
  assign led_clk      = led_clk_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75_frame_scanner.sv
`default_nettype none
// ============================================================================
// tb_hub75_frame_scanner : directed bench for hub75_frame_scanner at defaults
// Revision 1.0 - initial release
// ============================================================================
module tb_hub75_frame_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_rgb;
  logic       swap_req;
  logic       swap_pending, frame_start;
  logic       r1, g1, b1, r2, g2, b2;
  logic       a, b, c, d, lat, oe, led_clk;

  logic [2:0] top_rgb;
  logic [2:0] bot_rgb;
  logic [3:0] addr;
  assign top_rgb = {r1, g1, b1};
  assign bot_rgb = {r2, g2, b2};
  assign addr    = {d, c, b, a};

  int n_assert = 0;
  int n_fail   = 0;
  int fpos     = 0;

  localparam int ROW_P   = 388;
  localparam int FRAME_P = 6208;

  hub75_frame_scanner dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_rgb(wr_rgb), .swap_req(swap_req), .swap_pending(swap_pending),
    .frame_start(frame_start), .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2),
    .b2(b2), .a(a), .b(b), .c(c), .d(d), .lat(lat), .oe(oe), .led_clk(led_clk)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Cycle position within the current frame is tracked in fpos (0 = frame_start cycle)
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    fpos += n;
  endtask

  task automatic goto(input int target);
    if (target > fpos) step(target - fpos);
  endtask

  task automatic wait_fs(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_start !== 1'b1 && k < FRAME_P + 100);
    n_assert++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: frame_start=%b after %0d cycles, want 1", tag, frame_start, k);
    end
    fpos = 0;
  endtask

  task automatic write_px(input logic [4:0] x, input logic [4:0] y, input logic [2:0] v);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_rgb = v;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step(1);
    swap_req = 1'b0;
  endtask

  task automatic fill_back_zero();
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        wr_en = 1'b1; wr_x = 5'(x); wr_y = 5'(y); wr_rgb = 3'b000;
        step(1);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0; swap_req = 1'b0;
    step(3);
    n_assert++; if (oe !== 1'b1) begin n_fail++; $display("FAIL reset_oe: got %b want 1", oe); end
    n_assert++; if (lat !== 1'b0) begin n_fail++; $display("FAIL reset_lat: got %b want 0", lat); end
    n_assert++; if (led_clk !== 1'b0) begin n_fail++; $display("FAIL reset_led_clk: got %b want 0", led_clk); end
    n_assert++; if (addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr); end
    n_assert++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", swap_pending); end
    n_assert++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    n_assert++; if ({top_rgb, bot_rgb} !== 6'd0) begin n_fail++; $display("FAIL reset_rgb: got %b want 000000", {top_rgb, bot_rgb}); end
    reset = 1'b0;
    step(1);
    n_assert++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL reset_fs_pulse: got %b want 1", frame_start); end
    step(1);
    n_assert++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs_single: got %b want 0", frame_start); end
  endtask

  task automatic test_timing();
    int   led_rises = 0, lat_cyc = 0, oe_low = 0;
    int   lat_r1 = -1, lat_r2 = -1, fs_next = -1;
    logic pl, plat;
    wait_fs("timing_start");
    pl = led_clk; plat = lat;
    for (int i = 1; i <= FRAME_P + 50 && fs_next < 0; i++) begin
      step(1);
      if (i < ROW_P) begin
        if (led_clk && !pl) led_rises++;
        if (lat) lat_cyc++;
        if (!oe) oe_low++;
      end
      if (lat && !plat) begin
        if (lat_r1 < 0) lat_r1 = i;
        else if (lat_r2 < 0) lat_r2 = i;
      end
      if (frame_start) fs_next = i;
      pl = led_clk; plat = lat;
    end
    fpos = 0;
    n_assert++; if (led_rises != 32) begin n_fail++; $display("FAIL timing_led_rises: got %0d want 32", led_rises); end
    n_assert++; if (lat_cyc != 2) begin n_fail++; $display("FAIL timing_lat_width: got %0d want 2", lat_cyc); end
    n_assert++; if (oe_low != 256) begin n_fail++; $display("FAIL timing_oe_low: got %0d want 256", oe_low); end
    n_assert++; if (lat_r1 != 130) begin n_fail++; $display("FAIL timing_lat_offset: got %0d want 130", lat_r1); end
    n_assert++; if (lat_r2 - lat_r1 != ROW_P) begin n_fail++; $display("FAIL timing_row_period: got %0d want 388", lat_r2 - lat_r1); end
    n_assert++; if (fs_next != FRAME_P) begin n_fail++; $display("FAIL timing_frame_period: got %0d want 6208", fs_next); end
  endtask

  task automatic test_scan_data();
    write_px(5'd5, 5'd3, 3'b101);
    write_px(5'd5, 5'd19, 3'b011);
    pulse_swap();
    wait_fs("scan_frame");
    goto(3*ROW_P + 10);
    n_assert++; if (addr !== 4'd2) begin n_fail++; $display("FAIL scan_addr_prev_row: got %h want 2", addr); end
    goto(3*ROW_P + 18);
    n_assert++; if ({top_rgb, bot_rgb} !== 6'b000_000) begin n_fail++; $display("FAIL scan_col4: got %b want 000000", {top_rgb, bot_rgb}); end
    goto(3*ROW_P + 20);
    n_assert++; if ({top_rgb, bot_rgb} !== 6'b101_011) begin n_fail++; $display("FAIL scan_col5_low: got %b want 101011", {top_rgb, bot_rgb}); end
    goto(3*ROW_P + 22);
    n_assert++; if (led_clk !== 1'b1) begin n_fail++; $display("FAIL scan_led_high: got %b want 1", led_clk); end
    n_assert++; if (top_rgb !== 3'b101) begin n_fail++; $display("FAIL scan_top_rise6: got %b want 101", top_rgb); end
    n_assert++; if (bot_rgb !== 3'b011) begin n_fail++; $display("FAIL scan_bot_rise6: got %b want 011", bot_rgb); end
    goto(3*ROW_P + 26);
    n_assert++; if ({top_rgb, bot_rgb} !== 6'b000_000) begin n_fail++; $display("FAIL scan_col6: got %b want 000000", {top_rgb, bot_rgb}); end
    goto(3*ROW_P + 128);
    n_assert++; if (addr !== 4'b0011) begin n_fail++; $display("FAIL scan_addr_blank: got %b want 0011", addr); end
    n_assert++; if (oe !== 1'b1) begin n_fail++; $display("FAIL scan_oe_blank: got %b want 1", oe); end
    goto(3*ROW_P + 132);
    n_assert++; if (oe !== 1'b0) begin n_fail++; $display("FAIL scan_oe_display: got %b want 0", oe); end
  endtask

  task automatic test_swap_boundary();
    wait_fs("boundary_frame");
    goto(7*ROW_P + 50);
    write_px(5'd2, 5'd9, 3'b010);
    pulse_swap();
    n_assert++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL boundary_pending_set: got %b want 1", swap_pending); end
    goto(9*ROW_P + 10);
    n_assert++; if (top_rgb !== 3'b000) begin n_fail++; $display("FAIL boundary_early_content: got %b want 000", top_rgb); end
    goto(FRAME_P - 1);
    n_assert++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL boundary_pending_hold: got %b want 1", swap_pending); end
    step(1);
    fpos = 0;
    n_assert++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL boundary_fs: got %b want 1", frame_start); end
    n_assert++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL boundary_pending_clear: got %b want 0", swap_pending); end
    goto(3*ROW_P + 22);
    n_assert++; if (top_rgb !== 3'b000) begin n_fail++; $display("FAIL boundary_old_pixel: got %b want 000", top_rgb); end
    goto(9*ROW_P + 10);
    n_assert++; if (top_rgb !== 3'b010) begin n_fail++; $display("FAIL boundary_new_pixel: got %b want 010", top_rgb); end
  endtask

  task automatic test_simultaneous();
    goto(FRAME_P - 1);
    n_assert++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL simul_pending_pre: got %b want 0", swap_pending); end
    swap_req = 1'b1;
    wr_en = 1'b1; wr_x = 5'd0; wr_y = 5'd0; wr_rgb = 3'b111;
    step(1);
    swap_req = 1'b0; wr_en = 1'b0;
    fpos = 0;
    n_assert++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL simul_fs: got %b want 1", frame_start); end
    n_assert++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL simul_pending: got %b want 0", swap_pending); end
    n_assert++; if (top_rgb !== 3'b111) begin n_fail++; $display("FAIL simul_px00_first: got %b want 111", top_rgb); end
    goto(2);
    n_assert++; if ({top_rgb, bot_rgb} !== 6'b111_000) begin n_fail++; $display("FAIL simul_px00_rise: got %b want 111000", {top_rgb, bot_rgb}); end
    goto(3*ROW_P + 22);
    n_assert++; if ({top_rgb, bot_rgb} !== 6'b101_011) begin n_fail++; $display("FAIL simul_bank_swapped: got %b want 101011", {top_rgb, bot_rgb}); end
  endtask

  task automatic test_back_to_back();
    goto(5*ROW_P + 50);
    pulse_swap();
    goto(6*ROW_P + 50);
    n_assert++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL b2b_pending: got %b want 1", swap_pending); end
    pulse_swap();
    goto(FRAME_P - 1);
    n_assert++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL b2b_pending_hold: got %b want 1", swap_pending); end
    step(1);
    fpos = 0;
    n_assert++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL b2b_pending_clear: got %b want 0", swap_pending); end
    goto(2);
    n_assert++; if (top_rgb !== 3'b000) begin n_fail++; $display("FAIL b2b_px00: got %b want 000", top_rgb); end
    goto(9*ROW_P + 10);
    n_assert++; if (top_rgb !== 3'b010) begin n_fail++; $display("FAIL b2b_px29: got %b want 010", top_rgb); end
    goto(9*ROW_P + 128);
    n_assert++; if (addr !== 4'd9) begin n_fail++; $display("FAIL b2b_addr9: got %h want 9", addr); end
    goto(FRAME_P - 1);
    n_assert++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL b2b_no_queue: got %b want 0", swap_pending); end
    step(1);
    fpos = 0;
    goto(9*ROW_P + 10);
    n_assert++; if (top_rgb !== 3'b010) begin n_fail++; $display("FAIL b2b_single_toggle: got %b want 010", top_rgb); end
  endtask

  task automatic test_reset_mid();
    goto(9*ROW_P + 140);
    pulse_swap();
    n_assert++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending_pre: got %b want 1", swap_pending); end
    goto(9*ROW_P + 200);
    n_assert++; if (oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_display: got %b want 0", oe); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_assert++; if (oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_oe: got %b want 1", oe); end
    n_assert++; if (addr !== 4'd0) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0", addr); end
    n_assert++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending: got %b want 0", swap_pending); end
    n_assert++; if ({lat, led_clk} !== 2'b00) begin n_fail++; $display("FAIL rstmid_lat_clk: got %b want 00", {lat, led_clk}); end
    step(1);
    fpos = 0;
    n_assert++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL rstmid_fs: got %b want 1", frame_start); end
    n_assert++; if (top_rgb !== 3'b111) begin n_fail++; $display("FAIL rstmid_bank0: got %b want 111", top_rgb); end
    goto(FRAME_P - 1);
    n_assert++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_swap: got %b want 0", swap_pending); end
    step(1);
    n_assert++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL rstmid_frame_period: got %b want 1", frame_start); end
    n_assert++; if (top_rgb !== 3'b111) begin n_fail++; $display("FAIL rstmid_bank_kept: got %b want 111", top_rgb); end
  endtask

  initial begin
    test_reset();
    // Zero both banks so unwritten pixels read as 0
    fill_back_zero();
    pulse_swap();
    wait_fs("prefill_swap");
    fill_back_zero();
    test_timing();
    test_scan_data();
    test_swap_boundary();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
